// File: rtl/sim_exit_pkg.sv
// sim_exit_pkg
// Shared types and helpers for the end-of-simulation monitor.
//   state_e      : monitor phase (HOLD -> RUN -> DRAIN -> DONE)
//   EXIT_TIMEOUT : exit code reported when the cycle limit ends the run
//   sat_add      : unsigned add that clamps at the all-ones value of a
//                  caller-chosen width (up to SAT_W bits) instead of wrapping
package sim_exit_pkg;

   typedef enum logic [1:0] {
      HOLD,
      RUN,
      DRAIN,
      DONE
   } state_e;

   localparam logic [7:0] EXIT_TIMEOUT = 8'hFF;

   localparam int SAT_W = 64;

   // The limit is the all-ones value of 'width' bits, so callers narrower than
   // SAT_W get saturation at their own maximum rather than at 2^64-1.
   function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                input logic [SAT_W-1:0] b,
                                                input int unsigned      width);
      logic [SAT_W:0]   sum;
      logic [SAT_W-1:0] lim;
      sum = {1'b0, a} + {1'b0, b};
      lim = {SAT_W{1'b1}} >> (SAT_W - width);
      if (sum > {1'b0, lim}) begin
         return lim;
      end
      return sum[SAT_W-1:0];
   endfunction

endpackage

// File: rtl/sim_exit_prio_enc.sv
// sim_exit_prio_enc
// Lowest-set-bit encoder used to pick the failing channel.
// Ports:
//   req_vec  in   NUM_CH  request bits, bit 0 has highest priority
//   idx      out  IDX_W   index of the lowest set bit (0 when none set)
//   valid    out  1       at least one bit of req_vec is set
// IDX_W is one bit wider than the index needs so the parent can also
// express the out-of-range value NUM_CH with the same width.
module sim_exit_prio_enc #(
   parameter int NUM_CH = 4,
   parameter int IDX_W  = $clog2(NUM_CH) + 1
) (
   input  logic [NUM_CH-1:0] req_vec,
   output logic [IDX_W-1:0]  idx,
   output logic              valid
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (req_vec[i]) begin
            idx = IDX_W'(i);
         end
      end
   end

   assign valid = |req_vec;

endmodule

// File: rtl/sim_exit_monitor.sv
// sim_exit_monitor
// End-of-simulation monitor for test harnesses. Stretches the harness reset
// into a DUT reset, counts run cycles, gates the waveform dump window and
// merges NUM_CH completion channels plus a cycle timeout into one verdict.
// Ports:
//   clock, reset  harness clock; synchronous active-high reset
//   max_cycles    timeout limit, 0 disables the timeout
//   dump_start    first run cycle with dump_en high
//   dump_len      dump window length, 0 means open-ended
//   req_mask      channels that must report success for a pass
//   ch_success    per-channel success (pulse or level)
//   ch_fail       per-channel failure (pulse or level)
//   ch_code       per-channel 8-bit exit codes, sampled with ch_fail
//   dut_reset     stretched reset for the DUT
//   run_cycles    cycles since dut_reset fell, saturating
//   dump_en       waveform dump enable
//   done          verdict final, sticky until reset
//   pass/fail     verdict flags; timeout marks a timeout-caused fail
//   fail_ch       failing channel index, NUM_CH for timeout
//   exit_code     failing channel's code, 8'hFF on timeout, 0 on pass
module sim_exit_monitor #(
   parameter int NUM_CH       = 4,
   parameter int CYCLE_W      = 64,
   parameter int RESET_CYCLES = 16,
   parameter int DRAIN_CYCLES = 8
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [CYCLE_W-1:0]        max_cycles,
   input  logic [CYCLE_W-1:0]        dump_start,
   input  logic [CYCLE_W-1:0]        dump_len,
   input  logic [NUM_CH-1:0]         req_mask,
   input  logic [NUM_CH-1:0]         ch_success,
   input  logic [NUM_CH-1:0]         ch_fail,
   input  logic [8*NUM_CH-1:0]       ch_code,
   output logic                      dut_reset,
   output logic [CYCLE_W-1:0]        run_cycles,
   output logic                      dump_en,
   output logic                      done,
   output logic                      pass,
   output logic                      fail,
   output logic                      timeout,
   output logic [$clog2(NUM_CH):0]   fail_ch,
   output logic [7:0]                exit_code
);

   import sim_exit_pkg::*;

   localparam int FCH_W   = $clog2(NUM_CH) + 1;
   localparam int CNT_MAX = (RESET_CYCLES > DRAIN_CYCLES) ? RESET_CYCLES : DRAIN_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   // The shared counter is loaded with N-1 and the phase ends on the cycle it
   // reads zero, giving exactly N cycles in that phase.
   localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? CNT_W'(DRAIN_CYCLES - 1) : '0;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CYCLE_W-1:0] run_q, run_d;
   logic [NUM_CH-1:0]  ok_q, ok_d;
   logic               dut_reset_q, dut_reset_d;
   logic               dump_en_q, dump_en_d;
   logic               pass_q, pass_d;
   logic               fail_q, fail_d;
   logic               timeout_q, timeout_d;
   logic [FCH_W-1:0]   fail_ch_q, fail_ch_d;
   logic [7:0]         exit_code_q, exit_code_d;

   logic [FCH_W-1:0]   fail_idx;
   logic               fail_any;
   logic [7:0]         fail_code;
   logic               timeout_hit;
   logic               covered;
   logic               in_window;
   logic [CYCLE_W-1:0] dump_end;
   logic [CYCLE_W-1:0] run_inc;

   sim_exit_prio_enc #(
      .NUM_CH (NUM_CH),
      .IDX_W  (FCH_W)
   ) u_fail_enc (
      .req_vec (ch_fail),
      .idx     (fail_idx),
      .valid   (fail_any)
   );

   // fail_idx is only consumed when some ch_fail bit is set, so it is in range.
   assign fail_code   = ch_code[8*int'(fail_idx) +: 8];
   assign timeout_hit = (max_cycles != '0) && (run_q >= max_cycles);
   assign covered     = (((ok_q | ch_success) & req_mask) == req_mask) && (req_mask != '0);
   assign run_inc     = (run_q == '1) ? run_q : run_q + CYCLE_W'(1);

   // Window end saturates so a start near the top of the range cannot wrap
   // around and reopen the window at low cycle counts.
   assign dump_end  = CYCLE_W'(sat_add(64'(dump_start), 64'(dump_len), CYCLE_W));
   assign in_window = (run_q >= dump_start) && ((dump_len == '0) || (run_q < dump_end));

   // Next-state and datapath; every register holds by default and only the
   // active phase changes what it owns.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      run_d       = run_q;
      ok_d        = ok_q;
      dut_reset_d = dut_reset_q;
      pass_d      = pass_q;
      fail_d      = fail_q;
      timeout_d   = timeout_q;
      fail_ch_d   = fail_ch_q;
      exit_code_d = exit_code_q;

      case (state_q)
         HOLD: begin
            run_d = '0;
            if (cnt_q == '0) begin
               state_d     = RUN;
               dut_reset_d = 1'b0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RUN: begin
            run_d = run_inc;
            ok_d  = ok_q | ch_success;
            // fail outranks timeout, which outranks pass
            if (fail_any) begin
               fail_d      = 1'b1;
               fail_ch_d   = fail_idx;
               exit_code_d = fail_code;
            end else if (timeout_hit) begin
               fail_d      = 1'b1;
               timeout_d   = 1'b1;
               fail_ch_d   = FCH_W'(NUM_CH);
               exit_code_d = EXIT_TIMEOUT;
            end else if (covered) begin
               pass_d      = 1'b1;
               exit_code_d = '0;
            end
            if (fail_any || timeout_hit || covered) begin
               if (DRAIN_CYCLES == 0) begin
                  state_d = DONE;
               end else begin
                  state_d = DRAIN;
                  cnt_d   = DRAIN_LOAD;
               end
            end
         end
         DRAIN: begin
            run_d = run_inc;
            if (cnt_q == '0) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
         end
      endcase

      // Looks at the cycle count the counter holds now, so the dump enable
      // trails run_cycles by one clock; it drops on the same edge as DONE.
      dump_en_d = ((state_q == RUN) || (state_q == DRAIN)) && (state_d != DONE) && in_window;
   end

   // State register with synchronous reset back to HOLD.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= HOLD;
         cnt_q       <= HOLD_LOAD;
         run_q       <= '0;
         ok_q        <= '0;
         dut_reset_q <= 1'b1;
         dump_en_q   <= 1'b0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
         timeout_q   <= 1'b0;
         fail_ch_q   <= '0;
         exit_code_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         run_q       <= run_d;
         ok_q        <= ok_d;
         dut_reset_q <= dut_reset_d;
         dump_en_q   <= dump_en_d;
         pass_q      <= pass_d;
         fail_q      <= fail_d;
         timeout_q   <= timeout_d;
         fail_ch_q   <= fail_ch_d;
         exit_code_q <= exit_code_d;
      end
   end

   assign dut_reset  = dut_reset_q;
   assign run_cycles = run_q;
   assign dump_en    = dump_en_q;
   assign done       = (state_q == DONE);
   assign pass       = pass_q;
   assign fail       = fail_q;
   assign timeout    = timeout_q;
   assign fail_ch    = fail_ch_q;
   assign exit_code  = exit_code_q;

endmodule

// File: tb/tb_sim_exit_monitor.sv
// tb_sim_exit_monitor
// Scenario-driven bench: each scenario is a schedule of channel events. The
// expected verdict, its timing and the dump window are derived from the
// schedule and queued; a monitor checks every cycle and a scoreboard pops
// the queued verdict when the DUT first reports one.
module tb_sim_exit_monitor;

   localparam int NUM_CH       = 4;
   localparam int CYCLE_W      = 64;
   localparam int RESET_CYCLES = 16;
   localparam int DRAIN_CYCLES = 8;
   localparam int INF          = 1 << 30;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] max_cycles = '0;
   logic [63:0] dump_start = '0;
   logic [63:0] dump_len   = '0;
   logic [3:0]  req_mask   = '0;
   logic [3:0]  ch_success = '0;
   logic [3:0]  ch_fail    = '0;
   logic [31:0] ch_code    = '0;

   logic        dut_reset;
   logic [63:0] run_cycles;
   logic        dump_en;
   logic        done;
   logic        pass;
   logic        fail;
   logic        timeout;
   logic [2:0]  fail_ch;
   logic [7:0]  exit_code;

   sim_exit_monitor #(
      .NUM_CH       (NUM_CH),
      .CYCLE_W      (CYCLE_W),
      .RESET_CYCLES (RESET_CYCLES),
      .DRAIN_CYCLES (DRAIN_CYCLES)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .max_cycles (max_cycles),
      .dump_start (dump_start),
      .dump_len   (dump_len),
      .req_mask   (req_mask),
      .ch_success (ch_success),
      .ch_fail    (ch_fail),
      .ch_code    (ch_code),
      .dut_reset  (dut_reset),
      .run_cycles (run_cycles),
      .dump_en    (dump_en),
      .done       (done),
      .pass       (pass),
      .fail       (fail),
      .timeout    (timeout),
      .fail_ch    (fail_ch),
      .exit_code  (exit_code)
   );

   always #5 clock = ~clock;

   // vn: cycles after reset release at which the verdict is visible
   // dn: cycles after reset release at which done is visible
   typedef struct {
      int          vn;
      int          dn;
      logic [63:0] dstart;
      logic [63:0] dlen;
      logic        p;
      logic        f;
      logic        t;
      logic [2:0]  fch;
      logic [7:0]  code;
   } exp_t;

   exp_t scen_q[$];
   exp_t verdict_q[$];

   int checks   = 0;
   int failures = 0;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
      end
   endtask

   function automatic logic in_win(input longint unsigned r, input logic [63:0] s, input logic [63:0] l);
      return (r >= s) && ((l == '0) || ((r - s) < l));
   endfunction

   // Monitor: samples 1 time unit after each rising edge and counts edges
   // since the reset input was last seen low.
   int   mon_n      = 0;
   bit   mon_active = 1'b0;
   bit   mon_seen   = 1'b0;
   logic mon_rs;
   exp_t cur;
   exp_t vexp;

   always @(posedge clock) begin
      mon_rs = reset;
      #1;
      if (mon_rs) begin
         mon_n      = 0;
         mon_active = 1'b0;
         mon_seen   = 1'b0;
         checkOutput("rst_dut_reset", 64'(dut_reset), 64'd1);
         checkOutput("rst_run_cycles", run_cycles, 64'd0);
         checkOutput("rst_dump_en", 64'(dump_en), 64'd0);
         checkOutput("rst_done", 64'(done), 64'd0);
         checkOutput("rst_pass", 64'(pass), 64'd0);
         checkOutput("rst_fail", 64'(fail), 64'd0);
         checkOutput("rst_timeout", 64'(timeout), 64'd0);
         checkOutput("rst_fail_ch", 64'(fail_ch), 64'd0);
         checkOutput("rst_exit_code", 64'(exit_code), 64'd0);
      end else begin
         mon_n++;
         if (mon_n == 1) begin
            mon_active = (scen_q.size() > 0);
            if (mon_active) cur = scen_q.pop_front();
         end
         if (mon_active) begin
            checkOutput("dut_reset", 64'(dut_reset), 64'(mon_n < RESET_CYCLES));
            if (mon_n < RESET_CYCLES)
               checkOutput("run_cycles", run_cycles, 64'd0);
            else if (mon_n <= cur.dn)
               checkOutput("run_cycles", run_cycles, 64'(mon_n - RESET_CYCLES));
            else
               checkOutput("run_cycles", run_cycles, 64'(cur.dn - RESET_CYCLES));
            if (mon_n >= RESET_CYCLES + 1 && mon_n < cur.dn)
               checkOutput("dump_en", 64'(dump_en),
                           64'(in_win(64'(mon_n - RESET_CYCLES - 1), cur.dstart, cur.dlen)));
            else
               checkOutput("dump_en", 64'(dump_en), 64'd0);
            checkOutput("done", 64'(done), 64'(mon_n >= cur.dn));
            if (mon_n >= cur.vn) begin
               checkOutput("pass", 64'(pass), 64'(cur.p));
               checkOutput("fail", 64'(fail), 64'(cur.f));
               checkOutput("timeout", 64'(timeout), 64'(cur.t));
               checkOutput("fail_ch", 64'(fail_ch), 64'(cur.fch));
               checkOutput("exit_code", 64'(exit_code), 64'(cur.code));
            end else begin
               checkOutput("early_verdict", 64'({pass, fail, timeout}), 64'd0);
            end
            // Scoreboard: first verdict the DUT shows in this run.
            if ((pass || fail) && !mon_seen) begin
               mon_seen = 1'b1;
               checkOutput("sb_expected_verdict", 64'(verdict_q.size() > 0), 64'd1);
               if (verdict_q.size() > 0) begin
                  vexp = verdict_q.pop_front();
                  checkOutput("sb_pass", 64'(pass), 64'(vexp.p));
                  checkOutput("sb_fail", 64'(fail), 64'(vexp.f));
                  checkOutput("sb_timeout", 64'(timeout), 64'(vexp.t));
                  checkOutput("sb_fail_ch", 64'(fail_ch), 64'(vexp.fch));
                  checkOutput("sb_exit_code", 64'(exit_code), 64'(vexp.code));
               end
            end
         end
      end
   end

   // Scenario description: event times are in run cycles, -1 means never.
   int          s_succ[4];
   int          s_fail_t;
   logic [3:0]  s_fail_vec;
   logic [3:0]  s_req;
   logic [31:0] s_codes;
   logic [63:0] s_max;
   logic [63:0] s_dstart;
   logic [63:0] s_dlen;
   int          s_abort;

   task automatic clearScenario();
      for (int i = 0; i < 4; i++) s_succ[i] = -1;
      s_fail_t   = -1;
      s_fail_vec = '0;
      s_req      = '0;
      s_codes    = 32'h44332211;
      s_max      = '0;
      s_dstart   = '0;
      s_dlen     = '0;
      s_abort    = -1;
   endtask

   // Derives the verdict from the schedule, queues it, then plays the
   // schedule cycle by cycle after releasing reset.
   task automatic applyStimulus();
      exp_t e;
      int   tp, tf, tt, t_end, end_n, lf, r;
      bit   all_ok;
      all_ok = (s_req != '0);
      tp     = 0;
      for (int i = 0; i < 4; i++) begin
         if (s_req[i]) begin
            if (s_succ[i] < 0) all_ok = 1'b0;
            else if (s_succ[i] > tp) tp = s_succ[i];
         end
      end
      if (!all_ok) tp = INF;
      tf    = (s_fail_t >= 0) ? s_fail_t : INF;
      tt    = (s_max != '0) ? int'(s_max) : INF;
      t_end = tp;
      if (tf < t_end) t_end = tf;
      if (tt < t_end) t_end = tt;
      e.p = 1'b0; e.f = 1'b0; e.t = 1'b0; e.fch = '0; e.code = '0;
      if (tf == t_end) begin
         lf = 0;
         for (int i = 3; i >= 0; i--) if (s_fail_vec[i]) lf = i;
         e.f    = 1'b1;
         e.fch  = 3'(lf);
         e.code = s_codes[8*lf +: 8];
      end else if (tt == t_end) begin
         e.f    = 1'b1;
         e.t    = 1'b1;
         e.fch  = 3'(NUM_CH);
         e.code = 8'hFF;
      end else begin
         e.p = 1'b1;
      end
      e.vn     = RESET_CYCLES + t_end + 1;
      e.dn     = e.vn + DRAIN_CYCLES;
      e.dstart = s_dstart;
      e.dlen   = s_dlen;
      end_n    = (s_abort >= 0) ? e.vn + s_abort : e.dn + 3;
      scen_q.push_back(e);
      verdict_q.push_back(e);

      @(negedge clock);
      reset      = 1'b1;
      ch_success = '0;
      ch_fail    = '0;
      max_cycles = s_max;
      dump_start = s_dstart;
      dump_len   = s_dlen;
      req_mask   = s_req;
      ch_code    = s_codes;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      for (int n = 1; n < end_n; n++) begin
         @(negedge clock);
         r          = n - RESET_CYCLES;
         ch_success = '0;
         ch_fail    = '0;
         if (r >= 0) begin
            for (int i = 0; i < 4; i++) if (s_succ[i] == r) ch_success[i] = 1'b1;
            if (r == s_fail_t) ch_fail = s_fail_vec;
            // after the verdict the channels must be ignored
            if (r > t_end) begin
               ch_success = 4'($urandom);
               ch_fail    = 4'($urandom);
            end
         end
      end
      @(negedge clock);
      reset      = 1'b1;
      ch_success = '0;
      ch_fail    = '0;
   endtask

   initial begin
      // Two required channels succeed at runs 10 and 30; dump window 5..7.
      clearScenario();
      s_req = 4'b0101; s_succ[0] = 10; s_succ[2] = 30;
      s_dstart = 64'd5; s_dlen = 64'd3;
      applyStimulus();

      // Fail on channels 2 and 3 in the same cycle that would complete the pass.
      clearScenario();
      s_req = 4'b0101; s_succ[0] = 5; s_succ[2] = 20;
      s_fail_t = 20; s_fail_vec = 4'b1100; s_codes = 32'h772A5511;
      applyStimulus();

      // Timeout at 100 with no events; dump window parked near the top of the range.
      clearScenario();
      s_max = 64'd100;
      s_dstart = 64'hFFFF_FFFF_FFFF_FFFE; s_dlen = 64'd10;
      applyStimulus();

      // Reset lands three cycles into DRAIN, then a clean rerun.
      clearScenario();
      s_req = 4'b0101; s_succ[0] = 10; s_succ[2] = 30; s_abort = 3;
      applyStimulus();
      clearScenario();
      s_req = 4'b0101; s_succ[0] = 10; s_succ[2] = 30;
      applyStimulus();

      // Randomised schedules.
      for (int k = 0; k < 16; k++) begin
         clearScenario();
         s_req = 4'($urandom_range(0, 15));
         for (int i = 0; i < 4; i++)
            s_succ[i] = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 60));
         if ($urandom_range(0, 2) == 0) begin
            s_fail_t   = int'($urandom_range(0, 80));
            s_fail_vec = 4'($urandom_range(1, 15));
         end
         s_max    = ($urandom_range(0, 2) == 0) ? 64'd0 : 64'($urandom_range(1, 90));
         s_codes  = $urandom;
         s_dstart = 64'($urandom_range(0, 40));
         s_dlen   = 64'($urandom_range(0, 20));
         if (s_max == '0 && s_fail_t < 0) begin
            bit ends;
            ends = (s_req != '0);
            for (int i = 0; i < 4; i++) if (s_req[i] && s_succ[i] < 0) ends = 1'b0;
            if (!ends) s_max = 64'd120;
         end
         applyStimulus();
      end

      repeat (3) @(negedge clock);
      checkOutput("sb_all_verdicts_seen", 64'(verdict_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
